// File: rtl/vector_to_angle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vector_to_angle_pkg
// Brief    : Shared angle constants, 8-degree sin/cos tables and FSM states.
// Revision : 1.0
// ============================================================================
package vector_to_angle_pkg;

    localparam int NUM_ANGLES     = 45;
    localparam int ANGLE_STEP_DEG = 8;
    localparam int LUT_W          = 10;
    localparam int IDX_W          = 6;

    typedef logic signed [LUT_W-1:0] lut_t;

    // round(256*sin(8*i)) and round(256*cos(8*i)), i = 0..44
    localparam lut_t SIN_LUT [NUM_ANGLES] = '{
          10'sd0,    10'sd36,   10'sd71,  10'sd104,  10'sd136,  10'sd165,  10'sd190,  10'sd212,
        10'sd230,   10'sd243,  10'sd252,  10'sd256,  10'sd255,  10'sd248,  10'sd237,  10'sd222,
        10'sd202,   10'sd178,  10'sd150,  10'sd120,   10'sd88,   10'sd53,   10'sd18,  -10'sd18,
        -10'sd53,  -10'sd88, -10'sd120, -10'sd150, -10'sd178, -10'sd202, -10'sd222, -10'sd237,
       -10'sd248, -10'sd255, -10'sd256, -10'sd252, -10'sd243, -10'sd230, -10'sd212, -10'sd190,
       -10'sd165, -10'sd136, -10'sd104,  -10'sd71,  -10'sd36
    };

    localparam lut_t COS_LUT [NUM_ANGLES] = '{
        10'sd256,   10'sd254,  10'sd246,  10'sd234,  10'sd217,  10'sd196,  10'sd171,  10'sd143,
        10'sd112,    10'sd79,   10'sd44,    10'sd9,  -10'sd27,  -10'sd62,  -10'sd96, -10'sd128,
       -10'sd158,  -10'sd184, -10'sd207, -10'sd226, -10'sd241, -10'sd250, -10'sd255, -10'sd255,
       -10'sd250,  -10'sd241, -10'sd226, -10'sd207, -10'sd184, -10'sd158, -10'sd128,  -10'sd96,
        -10'sd62,   -10'sd27,    10'sd9,   10'sd44,   10'sd79,  10'sd112,  10'sd143,  10'sd171,
        10'sd196,   10'sd217,  10'sd234,  10'sd246,  10'sd254
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/angle_lut.sv
`default_nettype none
// ============================================================================
// Module   : angle_lut
// Brief    : Combinational 6-bit angle index to signed sin/cos lookup.
// Revision : 1.0
// ============================================================================
module angle_lut
    import vector_to_angle_pkg::*;
(
    input  logic [IDX_W-1:0] i_idx,
    output lut_t             o_sin,
    output lut_t             o_cos
);

    // Unused index codes read as zero so callers need no range guard.
    always_comb begin
        o_sin = '0;
        o_cos = '0;
        if (int'(i_idx) < NUM_ANGLES) begin
            o_sin = SIN_LUT[i_idx];
            o_cos = COS_LUT[i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_to_angle.sv
`default_nettype none
// ============================================================================
// Module   : vector_to_angle
// Brief    : Serial arg-max search of dx*cos+dy*sin over the 45 angle steps.
// Revision : 1.0
// ============================================================================
module vector_to_angle
    import vector_to_angle_pkg::*;
#(
    parameter int W = 12
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_angle,
    output logic                out_zero
);

    localparam int c_prod_w = W + LUT_W;
    localparam int c_dot_w  = W + LUT_W + 1;
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_ANGLES - 1);

    state_e                     state_q, state_d;
    logic signed [W-1:0]        dx_q, dx_d;
    logic signed [W-1:0]        dy_q, dy_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [IDX_W-1:0]           angle_q, angle_d;
    logic signed [c_dot_w-1:0]  best_q, best_d;
    logic                       zero_q, zero_d;

    lut_t                       w_sin, w_cos;
    logic signed [c_prod_w-1:0] w_prod_x, w_prod_y;
    logic signed [c_dot_w-1:0]  w_dot;
    logic                       w_better;

    angle_lut u_lut (
        .i_idx (idx_q),
        .o_sin (w_sin),
        .o_cos (w_cos)
    );

    always_comb begin
        w_prod_x = c_prod_w'(dx_q) * c_prod_w'(w_cos);
        w_prod_y = c_prod_w'(dy_q) * c_prod_w'(w_sin);
        w_dot    = c_dot_w'(w_prod_x) + c_dot_w'(w_prod_y);
        // Strict compare keeps the lowest index on ties.
        w_better = (idx_q == '0) || (w_dot > best_q);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            dx_q    <= '0;
            dy_q    <= '0;
            idx_q   <= '0;
            angle_q <= '0;
            best_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            idx_q   <= idx_d;
            angle_q <= angle_d;
            best_q  <= best_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        idx_d   = idx_q;
        angle_d = angle_q;
        best_d  = best_q;
        zero_d  = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    dx_d    = dx;
                    dy_d    = dy;
                    zero_d  = (dx == '0) && (dy == '0);
                    idx_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (w_better) begin
                    best_d  = w_dot;
                    angle_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == c_last_idx) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        out_angle = (state_q == ST_DONE) ? angle_q : '0;
        out_zero  = (state_q == ST_DONE) && zero_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_to_angle.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_to_angle
// Brief    : Scoreboard bench for vector_to_angle with an independent real model.
// Revision : 1.0
// ============================================================================
module tb_vector_to_angle;

    localparam int  W    = 12;
    localparam real C_PI = 3.14159265358979;

    logic                Clk = 1'b0;
    logic                Reset;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] dx;
    logic signed [W-1:0] dy;
    logic                out_valid;
    logic                out_ready;
    logic [5:0]          out_angle;
    logic                out_zero;

    int         errors = 0;
    int         checks = 0;
    int         cyc    = 0;
    int         n_xfer = 0;
    logic       ov_prev = 1'b0;
    logic [5:0] exp_ang = '0;
    logic       exp_zero = 1'b0;
    logic [6:0] sb[$];
    int         acc_q[$];

    vector_to_angle #(.W(W)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dx        (dx),
        .dy        (dy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_angle (out_angle),
        .out_zero  (out_zero)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic int model_angle(input int x, input int y);
        longint best = 0;
        longint d;
        int     bi = 0;
        real    a;
        for (int i = 0; i < 45; i++) begin
            a = real'(8 * i) * C_PI / 180.0;
            d = longint'(x) * rnd(256.0 * $cos(a)) + longint'(y) * rnd(256.0 * $sin(a));
            if (i == 0 || d > best) begin
                best = d;
                bi   = i;
            end
        end
        return bi;
    endfunction

    // Scoreboard: push on accept, compare every DONE cycle, pop on transfer.
    always @(negedge Clk) begin : mon
        int lat;
        if (Reset) begin
            ov_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back({exp_zero, exp_ang});
                acc_q.push_back(cyc);
            end
            if (out_valid) begin
                check("in_ready_in_done", 32'(in_ready), 0);
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 32'(out_valid), 0);
                end else begin
                    if (!ov_prev) begin
                        lat = cyc - acc_q[0];
                        check("latency", lat, 46);
                    end
                    check("out_angle", 32'(out_angle), 32'(sb[0][5:0]));
                    check("out_zero", 32'(out_zero), 32'(sb[0][6]));
                    if (out_ready) begin
                        void'(sb.pop_front());
                        void'(acc_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            ov_prev = out_valid;
        end
    end

    task automatic send(input int x, input int y, input int ang, input bit zr);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge Clk); #2;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
        exp_ang  = 6'(ang);
        exp_zero = zr;
        dx       = W'(x);
        dy       = W'(y);
        in_valid = 1'b1;
        @(posedge Clk); #2;
        in_valid = 1'b0;
        dx       = W'($urandom);
        dy       = W'($urandom);
    endtask

    task automatic send_model(input int x, input int y);
        send(x, y, model_angle(x, y), (x == 0) && (y == 0));
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge Clk); #2;
            n++;
        end
        if (n >= 300) check("drain_timeout", sb.size(), 0);
    endtask

    initial begin : main
        int n;
        int x0;
        int seen;
        Reset     = 1'b1;
        in_valid  = 1'b0;
        dx        = '0;
        dy        = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge Clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_angle", 32'(out_angle), 0);
        check("rst_out_zero", 32'(out_zero), 0);
        Reset = 1'b0;
        @(posedge Clk); #2;

        send(100, 0, 0, 0);          drain();
        send(0, 100, 11, 0);         drain();
        send(0, -100, 34, 0);        drain();
        send(-100, 0, 22, 0);        drain();
        send(0, 0, 0, 1);            drain();
        send(-2048, -2048, 28, 0);   drain();
        send_model(-2048, 0);        drain();
        send_model(2047, 2047);      drain();
        send_model(0, -2048);        drain();
        for (int k = 0; k < 8; k++) begin
            send_model(int'($urandom_range(4095)) - 2048, int'($urandom_range(4095)) - 2048);
            drain();
        end

        // Backpressure with a competing request held in DONE
        out_ready = 1'b0;
        send(100, 0, 0, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge Clk); #2;
            n++;
        end
        check("bp_valid_seen", 32'(out_valid), 1);
        x0       = n_xfer;
        exp_ang  = 6'd11;
        dx       = W'(0);
        dy       = W'(100);
        in_valid = 1'b1;
        repeat (10) begin
            @(posedge Clk); #2;
        end
        check("bp_no_xfer", n_xfer - x0, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge Clk); #2;
        check("bp_one_xfer", n_xfer - x0, 1);
        check("bp_in_ready_after", 32'(in_ready), 1);
        check("bp_valid_dropped", 32'(out_valid), 0);
        repeat (50) @(posedge Clk);
        #2;
        check("bp_no_second", 32'(out_valid), 0);
        check("bp_sb_empty", sb.size(), 0);

        // Reset in the middle of SEARCH abandons the conversion
        send(100, 0, 0, 0);
        repeat (20) begin
            @(posedge Clk); #2;
        end
        Reset = 1'b1;
        sb.delete();
        acc_q.delete();
        @(posedge Clk); #2;
        Reset = 1'b0;
        check("rst_mid_in_ready", 32'(in_ready), 1);
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (out_valid) seen++;
            @(posedge Clk); #2;
        end
        check("rst_mid_no_valid", seen, 0);
        send(100, 0, 0, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
